// File: rtl/mcp_hold_reg.sv
// Multi-channel multicycle-path capture register: each channel stages a word on SET
// and commits it to get only after the source has held stable for HOLD cycles.
module mcp_hold_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned HOLD      = 2,
  parameter int unsigned INIT_MODE = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS-1:0]       SET,
  input  logic [CHANNELS*WIDTH-1:0] val,
  input  logic [CHANNELS-1:0]       err_clr,
  output logic [CHANNELS*WIDTH-1:0] get,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       err
);

  localparam int unsigned CW = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
  localparam logic [CW-1:0] LAST = CW'((HOLD == 0) ? 0 : HOLD - 1);

  function automatic logic [WIDTH-1:0] init_word();
    logic [WIDTH-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w[i] = (INIT_MODE == 0) && (i % 2 == 1);
    end
    return w;
  endfunction

  localparam logic [WIDTH-1:0] INIT = init_word();

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] w_val;
    logic [WIDTH-1:0] r_get, w_get_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;

    assign w_val = val[c*WIDTH +: WIDTH];

    if (HOLD == 0) begin : g_bypass
      // Legacy single-cycle behaviour: no staging, no stability check.
      always_comb begin
        w_get_nxt  = r_get;
        w_done_nxt = 1'b0;
        w_err_nxt  = r_err & ~err_clr[c];
        if (SET[c]) begin
          w_get_nxt  = w_val;
          w_done_nxt = 1'b1;
        end
      end
      assign busy[c] = 1'b0;
    end else begin : g_hold
      state_t           r_state, w_state_nxt;
      logic [WIDTH-1:0] r_stg, w_stg_nxt;
      logic [CW-1:0]    r_cnt, w_cnt_nxt;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_state <= S_IDLE;
          r_stg   <= '0;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_stg   <= w_stg_nxt;
          r_cnt   <= w_cnt_nxt;
        end
      end

      // SET takes priority over both the commit and the instability check.
      always_comb begin
        w_state_nxt = r_state;
        w_stg_nxt   = r_stg;
        w_cnt_nxt   = r_cnt;
        w_get_nxt   = r_get;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err & ~err_clr[c];
        if (SET[c]) begin
          w_state_nxt = S_HOLD;
          w_stg_nxt   = w_val;
          w_cnt_nxt   = '0;
        end else if (r_state == S_HOLD) begin
          if (w_val != r_stg) begin
            w_stg_nxt = w_val;
            w_cnt_nxt = '0;
            w_err_nxt = 1'b1;
          end else if (r_cnt == LAST) begin
            w_get_nxt   = r_stg;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      assign busy[c] = (r_state == S_HOLD);
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_get  <= INIT;
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        r_get  <= w_get_nxt;
        r_done <= w_done_nxt;
        r_err  <= w_err_nxt;
      end
    end

    assign get[c*WIDTH +: WIDTH] = r_get;
    assign done[c]               = r_done;
    assign err[c]                = r_err;
  end

endmodule

// File: tb/tb_mcp_hold_reg.sv
// Bench for mcp_hold_reg: a HOLD=2 instance and a HOLD=0 bypass instance share stimulus
// and are compared each cycle against a timestamp-based reference model.
module tb_mcp_hold_reg;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst;
  logic [1:0]  set;
  logic [15:0] val;
  logic [1:0]  clr;
  logic [15:0] get_a, get_b;
  logic [1:0]  busy_a, done_a, err_a, busy_b, done_b, err_b;

  int n_chk = 0;
  int n_pass = 0;

  mcp_hold_reg #(.WIDTH(8), .CHANNELS(2), .HOLD(2), .INIT_MODE(0)) dut_a (
    .CLK(clk), .RST(rst), .SET(set), .val(val), .err_clr(clr),
    .get(get_a), .busy(busy_a), .done(done_a), .err(err_a));

  mcp_hold_reg #(.WIDTH(8), .CHANNELS(2), .HOLD(0), .INIT_MODE(1)) dut_b (
    .CLK(clk), .RST(rst), .SET(set), .val(val), .err_clr(clr),
    .get(get_b), .busy(busy_b), .done(done_b), .err(err_b));

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  // Reference model: a pending capture remembers the edge index at which its
  // stability window began; it commits once HOLD further edges saw the same value.
  int         hold_of [2] = '{2, 0};
  logic [7:0] init_of [2] = '{8'hAA, 8'h00};
  int         edge_n;
  bit         m_pend [2][2];
  int         m_start[2][2];
  logic [7:0] m_pv   [2][2];
  logic [7:0] m_get  [2][2];
  bit         m_done [2][2];
  bit         m_err  [2][2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) begin
        m_pend[i][c] = 0; m_start[i][c] = 0; m_pv[i][c] = '0;
        m_get[i][c] = init_of[i]; m_done[i][c] = 0; m_err[i][c] = 0;
      end
  endtask

  task automatic model_edge();
    logic [7:0] v;
    edge_n++;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) begin
        v = val[c*8 +: 8];
        m_done[i][c] = 0;
        if (clr[c]) m_err[i][c] = 0;
        if (hold_of[i] == 0) begin
          if (set[c]) begin m_get[i][c] = v; m_done[i][c] = 1; end
        end else if (set[c]) begin
          m_pend[i][c] = 1; m_pv[i][c] = v; m_start[i][c] = edge_n;
        end else if (m_pend[i][c]) begin
          if (v != m_pv[i][c]) begin
            m_pv[i][c] = v; m_start[i][c] = edge_n; m_err[i][c] = 1;
          end else if (edge_n - m_start[i][c] == hold_of[i]) begin
            m_get[i][c] = m_pv[i][c]; m_pend[i][c] = 0; m_done[i][c] = 1;
          end
        end
      end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic [15:0] eg [2];
    logic [1:0]  eb [2], ed [2], ee [2];
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) begin
        eg[i][c*8 +: 8] = m_get[i][c];
        eb[i][c] = m_pend[i][c];
        ed[i][c] = m_done[i][c];
        ee[i][c] = m_err[i][c];
      end
    chk("A.get", 32'(get_a), 32'(eg[0]));
    chk("A.busy", 32'(busy_a), 32'(eb[0]));
    chk("A.done", 32'(done_a), 32'(ed[0]));
    chk("A.err", 32'(err_a), 32'(ee[0]));
    chk("B.get", 32'(get_b), 32'(eg[1]));
    chk("B.busy", 32'(busy_b), 32'(eb[1]));
    chk("B.done", 32'(done_b), 32'(ed[1]));
    chk("B.err", 32'(err_b), 32'(ee[1]));
  endtask

  task automatic step(input logic [1:0] s, input logic [15:0] v, input logic [1:0] c);
    set = s; val = v; clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [15:0] rv;
    logic [1:0]  rs, rc;
    edge_n = 0;
    set = '0; val = '0; clr = '0;
    rst = 1'b1;
    model_reset();
    #5;
    chk("rst.A.get", 32'(get_a), 32'h0000AAAA);
    chk("rst.B.get", 32'(get_b), 32'h00000000);
    chk("rst.A.flags", {26'd0, busy_a, done_a, err_a}, 32'd0);
    chk("rst.B.flags", {26'd0, busy_b, done_b, err_b}, 32'd0);
    rst = 1'b0;
    clk_en = 1'b1;

    // Stable capture on ch0
    step(2'b00, 16'h005C, 2'b00);
    step(2'b01, 16'h005C, 2'b00);
    chk("cap.busy", 32'(busy_a[0]), 32'd1);
    chk("byp.get", 32'(get_b[7:0]), 32'h5C);
    step(2'b00, 16'h005C, 2'b00);
    step(2'b00, 16'h005C, 2'b00);
    chk("cap.get", 32'(get_a[7:0]), 32'h5C);
    chk("cap.done", 32'(done_a[0]), 32'd1);
    step(2'b00, 16'h005C, 2'b00);

    // Instability on ch1, then sticky clear
    step(2'b10, 16'h115C, 2'b00);
    step(2'b00, 16'h125C, 2'b00);
    chk("inst.err", 32'(err_a[1]), 32'd1);
    for (int k = 0; k < 4; k++) step(2'b00, 16'h125C, 2'b00);
    chk("inst.get", 32'(get_a[15:8]), 32'h12);
    step(2'b00, 16'h125C, 2'b10);
    chk("inst.clr", 32'(err_a[1]), 32'd0);

    // Restart in HOLD and SET on the commit edge
    step(2'b01, 16'h1201, 2'b00);
    step(2'b01, 16'h1202, 2'b00);
    step(2'b00, 16'h1202, 2'b00);
    step(2'b01, 16'h1202, 2'b00);
    chk("rsc.nodone", 32'(done_a[0]), 32'd0);
    chk("rsc.noerr", 32'(err_a[0]), 32'd0);
    step(2'b00, 16'h1202, 2'b00);
    step(2'b00, 16'h1202, 2'b00);
    chk("rsc.get", 32'(get_a[7:0]), 32'h02);

    // Asynchronous reset mid-HOLD
    step(2'b01, 16'h1233, 2'b00);
    step(2'b00, 16'h1233, 2'b00);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("mid.get", 32'(get_a), 32'h0000AAAA);
    chk("mid.busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) step(2'b00, 16'h1233, 2'b00);

    // Randomized traffic with a small value alphabet so holds often succeed
    rv = 16'h0000;
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < 2; c++)
        if ($urandom_range(3) == 0) rv[c*8 +: 8] = 8'($urandom_range(3));
      rs[0] = ($urandom_range(5) == 0);
      rs[1] = ($urandom_range(5) == 0);
      rc[0] = ($urandom_range(7) == 0);
      rc[1] = ($urandom_range(7) == 0);
      step(rs, rv, rc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
